// File: rtl/prog_sequencer.sv
// Program sequencer: steps the fetch unit through programs 1..NUM_PROGS.
// For each program it loads the start address into the PC, holds fetch with
// Start while the core settles, lets the program run, and finishes on a
// decoded halt or on a watchdog timeout. All outputs are decoded from
// registered state, so no input reaches an output combinationally.
module prog_sequencer #(
    parameter int NUM_PROGS  = 3,
    parameter int PC_W       = 11,
    parameter int P0_BASE    = 0,
    parameter int P1_BASE    = 200,
    parameter int P2_BASE    = 400,
    parameter int P3_BASE    = 600,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic            Halt,
    output logic            Start,
    output logic            LoadEn,
    output logic [PC_W-1:0] LoadAddr,
    output logic [1:0]      ProgSel,
    output logic            Busy,
    output logic            Ack,
    output logic            Timeout,
    output logic [15:0]     RunCycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    // The hold counter runs 0..START_HOLD-1, so this width is always enough.
    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [15:0]       WD_LAST   = 16'(TIMEOUT - 1);
    localparam logic [15:0]       WD_LIMIT  = 16'(TIMEOUT);
    localparam logic [1:0]        SEL_LAST  = 2'(NUM_PROGS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       watchdog;
    logic [1:0]        prog_sel;
    logic              timeout_q;
    logic [15:0]       run_cycles_q;

    logic              hold_done;
    logic              wd_expired;
    logic [16:0]       run_sum;
    logic [15:0]       run_sat;

    assign hold_done  = (hold_cnt == HOLD_LAST);
    assign wd_expired = (watchdog == WD_LAST);

    // Cycle count for a halted program; saturates rather than wrapping.
    assign run_sum = {1'b0, watchdog} + 17'd1;
    assign run_sat = run_sum[16] ? 16'hFFFF : run_sum[15:0];

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        Start     = 1'b0;
        LoadEn    = 1'b0;
        Busy      = 1'b0;
        Ack       = 1'b0;
        case (state)
            S_IDLE: begin
                if (Req) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                Start     = 1'b1;
                LoadEn    = 1'b1;
                Busy      = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                Start = 1'b1;
                Busy  = 1'b1;
                if (hold_done) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                if (Halt || wd_expired) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                Ack       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Hold counter: cleared in LOAD, advances through HOLD.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_cnt <= '0;
        end else if (state == S_LOAD) begin
            hold_cnt <= '0;
        end else if (state == S_HOLD && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Watchdog: cleared on the way into RUN, counts every RUN cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            watchdog <= '0;
        end else if (state == S_HOLD && hold_done) begin
            watchdog <= '0;
        end else if (state == S_RUN) begin
            watchdog <= watchdog + 16'd1;
        end
    end

    // Completion record: halt takes priority over the watchdog; a new LOAD
    // clears the sticky timeout flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timeout_q    <= 1'b0;
            run_cycles_q <= '0;
        end else if (state == S_LOAD) begin
            timeout_q <= 1'b0;
        end else if (state == S_RUN) begin
            if (Halt) begin
                run_cycles_q <= run_sat;
            end else if (wd_expired) begin
                timeout_q    <= 1'b1;
                run_cycles_q <= WD_LIMIT;
            end
        end
    end

    // Program index advances as DONE exits, wrapping after the last program.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prog_sel <= '0;
        end else if (state == S_DONE) begin
            prog_sel <= (prog_sel == SEL_LAST) ? 2'd0 : prog_sel + 2'd1;
        end
    end

    // Start address of the selected program.
    always_comb begin
        case (prog_sel)
            2'd0:    LoadAddr = PC_W'(P0_BASE);
            2'd1:    LoadAddr = PC_W'(P1_BASE);
            2'd2:    LoadAddr = PC_W'(P2_BASE);
            default: LoadAddr = PC_W'(P3_BASE);
        endcase
    end

    assign ProgSel   = prog_sel;
    assign Timeout   = timeout_q;
    assign RunCycles = run_cycles_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: directed scenarios plus random Req/Halt
// traffic, every cycle compared against a timeline-based reference model.
module tb_prog_sequencer;

    localparam int SH   = 2;
    localparam int TO   = 16;
    localparam int NP   = 3;
    localparam int PCW  = 11;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Req;
    logic           Halt;
    logic           Start;
    logic           LoadEn;
    logic [PCW-1:0] LoadAddr;
    logic [1:0]     ProgSel;
    logic           Busy;
    logic           Ack;
    logic           Timeout;
    logic [15:0]    RunCycles;

    int n_vec = 0;
    int n_err = 0;

    int bases [4] = '{0, 200, 400, 600};

    prog_sequencer #(
        .NUM_PROGS (NP),
        .PC_W      (PCW),
        .P0_BASE   (0),
        .P1_BASE   (200),
        .P2_BASE   (400),
        .P3_BASE   (600),
        .START_HOLD(SH),
        .TIMEOUT   (TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Halt     (Halt),
        .Start    (Start),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .ProgSel  (ProgSel),
        .Busy     (Busy),
        .Ack      (Ack),
        .Timeout  (Timeout),
        .RunCycles(RunCycles)
    );

    always #5 Clk = ~Clk;

    // Reference model: m_age counts cycles since the request was accepted
    // (1 = load cycle, 2..SH+1 = settle, SH+2.. = running); 0 means not busy.
    int m_age;
    bit m_done;
    int m_sel;
    bit m_to;
    int m_rc;
    int m_r;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_age  = 0;
            m_done = 0;
            m_sel  = 0;
            m_to   = 0;
            m_rc   = 0;
        end else if (m_done) begin
            m_done = 0;
            m_sel  = (m_sel + 1) % NP;
        end else if (m_age == 0) begin
            if (Req === 1'b1) m_age = 1;
        end else if (m_age < SH + 2) begin
            if (m_age == 1) m_to = 0;
            m_age++;
        end else begin
            m_r = m_age - 1 - SH;
            if (Halt === 1'b1) begin
                m_rc = m_r; m_done = 1; m_age = 0;
            end else if (m_r == TO) begin
                m_to = 1; m_rc = TO; m_done = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    function automatic int run_idx();
        return (m_age >= SH + 2) ? m_age - 1 - SH : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic compare_all();
        check("start",     32'(Start),     32'(m_age >= 1 && m_age <= SH + 1));
        check("load_en",   32'(LoadEn),    32'(m_age == 1));
        check("busy",      32'(Busy),      32'(m_age > 0));
        check("ack",       32'(Ack),       32'(m_done));
        check("prog_sel",  32'(ProgSel),   32'(m_sel));
        check("load_addr", 32'(LoadAddr),  32'(bases[m_sel]));
        check("run_cyc",   32'(RunCycles), 32'(m_rc));
        // The flag is cleared by the load cycle; its value during that cycle
        // is not pinned down, so it is compared from the next cycle on.
        if (m_age != 1) check("timeout", 32'(Timeout), 32'(m_to));
    endtask

    task automatic tick(input logic r, input logic h);
        @(negedge Clk);
        compare_all();
        Req  = r;
        Halt = h;
    endtask

    // Run one program from IDLE; halt_at = 0 means let the watchdog fire.
    task automatic run_prog(input logic keep_req, input int halt_at);
        bit seen_ack;
        tick(1'b1, 1'b0);
        seen_ack = 0;
        for (int n = 0; n < 200 && !seen_ack; n++) begin
            @(negedge Clk);
            compare_all();
            if (m_done) seen_ack = 1;
            Req  = keep_req;
            Halt = (halt_at > 0 && run_idx() == halt_at);
        end
        if (!seen_ack) check("ack_never_seen", 32'd0, 32'd1);
    endtask

    initial begin
        Reset = 1'b0;
        Req   = 1'b0;
        Halt  = 1'b0;
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst_start",   32'(Start),     32'd0);
        check("rst_busy",    32'(Busy),      32'd0);
        check("rst_addr",    32'(LoadAddr),  32'd0);
        check("rst_runcyc",  32'(RunCycles), 32'd0);

        // Single request, halt on run cycle 10.
        run_prog(1'b0, 10);
        check("halt10_runcyc",  32'(RunCycles), 32'd10);
        check("halt10_timeout", 32'(Timeout),   32'd0);
        tick(1'b0, 1'b0);
        check("halt10_progsel", 32'(ProgSel),   32'd1);
        check("halt10_addr",    32'(LoadAddr),  32'd200);

        // Req held high across programs; wraps back to program 1.
        for (int p = 0; p < 4; p++) run_prog(1'b1, 5);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // Watchdog expiry, then halt coinciding with the last watchdog cycle.
        run_prog(1'b0, 0);
        check("wd_runcyc",  32'(RunCycles), 32'(TO));
        check("wd_timeout", 32'(Timeout),   32'd1);
        tick(1'b0, 1'b0);
        run_prog(1'b0, TO);
        check("tie_runcyc",  32'(RunCycles), 32'(TO));
        check("tie_timeout", 32'(Timeout),   32'd0);
        tick(1'b0, 1'b0);

        // Reach program 3 in RUN, then reset asynchronously between edges.
        for (int p = 0; p < 4 && m_sel != 2; p++) begin
            run_prog(1'b0, 4);
            tick(1'b0, 1'b0);
        end
        check("reach_sel2", 32'(ProgSel), 32'd2);
        tick(1'b1, 1'b0);
        for (int n = 0; n < 20 && run_idx() != 3; n++) tick(1'b0, 1'b0);
        check("mid_run_busy", 32'(Busy), 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("arst_start",   32'(Start),     32'd0);
        check("arst_busy",    32'(Busy),      32'd0);
        check("arst_loaden",  32'(LoadEn),    32'd0);
        check("arst_progsel", 32'(ProgSel),   32'd0);
        check("arst_runcyc",  32'(RunCycles), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        run_prog(1'b0, 2);
        tick(1'b0, 1'b0);

        // Random traffic: stray Req/Halt in every state, occasional timeouts.
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 11) == 0));
        end
        tick(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Top-level program controller for the CPU core.
- Sequences programs 1..NUM_PROGS through the fetch unit:
  - loads each program's start address into the PC;
  - holds fetch with Start while the core settles;
  - releases fetch into execution;
  - detects completion via the decoded halt instruction or a watchdog timeout.
- Sits between the testbench/top-level request handshake and the fetch unit's Start and PC-load inputs.

Parameters:
- NUM_PROGS, 3, number of programs in the series (1..4)
- PC_W, 11, program-counter width
- P0_BASE, 0, start address of program 1
- P1_BASE, 200, start address of program 2
- P2_BASE, 400, start address of program 3
- P3_BASE, 600, start address of program 4
- START_HOLD, 2, cycles Start stays asserted after load (>=1)
- TIMEOUT, 4096, maximum RUN cycles before forced completion (2..65535)

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  request to run the next program; level, sampled in IDLE only
- Halt  in  1  halt instruction decoded this cycle; meaningful in RUN only
- Start  out  1  to fetch unit: hold PC while high
- LoadEn  out  1  to fetch unit: load PC from LoadAddr this edge
- LoadAddr  out  PC_W  start address of current program
- ProgSel  out  2  index of current/next program (0-based)
- Busy  out  1  high in LOAD, HOLD, RUN
- Ack  out  1  one-cycle completion pulse
- Timeout  out  1  last program ended by watchdog; sticky
- RunCycles  out  16  RUN-cycle count of the last completed program; held

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE, ProgSel=0, hold counter=0, watchdog=0, RunCycles=0, Timeout=0. All Moore outputs decode to Start=0, LoadEn=0, LoadAddr=0, Busy=0, Ack=0.
- FSM states: IDLE, LOAD, HOLD, RUN, DONE. All outputs are decoded from registered state/counters (Moore); there is no combinational path from input to output.
- IDLE:
  - Req=1 at an edge -> LOAD.
  - Otherwise stay.
- LOAD (exactly 1 cycle):
  - LoadEn=1, Start=1, Busy=1.
  - LoadAddr=base[ProgSel].
  - Timeout cleared.
  - Hold counter cleared.
  - -> HOLD.
- HOLD:
  - Start=1, Busy=1, LoadEn=0.
  - Lasts START_HOLD cycles, counted by the hold counter.
  - Then -> RUN; watchdog cleared on entry.
- RUN:
  - Start=0, Busy=1.
  - Watchdog increments each cycle.
  - Halt=1 -> DONE; RunCycles := watchdog+1.
  - Else watchdog==TIMEOUT-1 -> DONE; Timeout:=1, RunCycles:=TIMEOUT.
  - Halt and timeout in the same cycle: Halt wins, Timeout stays 0.
- DONE (1 cycle):
  - Ack=1, Busy=0.
  - At exit, ProgSel increments; NUM_PROGS-1 wraps to 0.
  - -> IDLE.
- Latency: Req sampled at edge E -> LOAD in cycle E+1, HOLD in E+2..E+1+START_HOLD, RUN from E+2+START_HOLD.
- Req held high continuously: the next program's LOAD follows one IDLE cycle after DONE.
- Req outside IDLE and Halt outside RUN are ignored; neither is queued.
- LoadAddr holds base[ProgSel] in every state except under reset.
- RunCycles saturates at 65535; it is unreachable with legal TIMEOUT.

Test Plan:
1. Reset, pulse Req one cycle at edge 0 -> LoadEn=1 and LoadAddr=0 in cycle 1; Start=1 in cycles 1-3; Start=0 and Busy=1 from cycle 4.
2. Continuing 1, Halt=1 for one cycle on RUN cycle 10 -> Ack=1 exactly one cycle, RunCycles=10, Timeout=0, ProgSel=1; next Req gives LoadAddr=200.
3. Req held high across three programs with Halt after 5 RUN cycles each -> LoadAddr sequence 0, 200, 400, 0; one IDLE cycle between each Ack and the next LoadEn; ProgSel wraps 2->0.
4. TIMEOUT=16, no Halt -> DONE after 16 RUN cycles, Timeout=1, RunCycles=16; next LOAD clears Timeout to 0.
5. TIMEOUT=16, Halt on the 16th RUN cycle -> Timeout=0, RunCycles=16; Halt pulses during IDLE/HOLD and Req pulses during RUN -> no state change.
6. Assert Reset asynchronously (between edges) mid-RUN with ProgSel=2 -> Start, Busy and LoadEn drop immediately; ProgSel=0, RunCycles=0; the next Req loads address 0.
